// File: rtl/blue_centroid.sv
// ---------------------------------------------------------------------------
// blue_centroid
//   Classifies each incoming pixel as blue or not, accumulates the count and
//   the x/y coordinate sums of blue pixels over a frame, and at frame end
//   divides the sums by the count with two parallel serial restoring dividers
//   to produce a registered centroid. The next frame accumulates while the
//   division runs.
//
// Ports
//   clock_in    : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   pix_valid   : qualifies pix_x/pix_y/pix_r/pix_g/pix_b
//   pix_x/pix_y : pixel column/row (10 bits)
//   pix_r/g/b   : colour channels (COLOR_W bits)
//   frame_end   : one-cycle pulse closing the current frame
//   blue_x/y    : centroid column/row
//   found       : last result had at least MIN_PIXELS blue pixels
//   coord_valid : one-cycle pulse when blue_x/blue_y/found update
//   overrun     : one-cycle pulse when a frame_end arrives while busy
// ---------------------------------------------------------------------------
module blue_centroid #(
  parameter int COLOR_W    = 8,
  parameter int B_MIN      = 128,
  parameter int MARGIN     = 32,
  parameter int MIN_PIXELS = 64
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               pix_valid,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  input  logic               frame_end,
  output logic [9:0]         blue_x,
  output logic [9:0]         blue_y,
  output logic               found,
  output logic               coord_valid,
  output logic               overrun
);

  localparam int CNT_W = 19;
  localparam int SUM_W = 29;

  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   LP_MIN_PIX = CNT_W'(MIN_PIXELS);
  localparam logic [COLOR_W:0]   LP_B_MIN   = (COLOR_W+1)'(B_MIN);
  localparam logic [COLOR_W:0]   LP_MARGIN  = (COLOR_W+1)'(MARGIN);
  localparam logic [4:0]         LAST_ITER  = 5'd28;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_DONE
  } state_t;

  // One restoring-division step. The partial remainder is always below the
  // divisor, so it fits in CNT_W bits; the trial value needs one extra bit.
  // Returns {next_remainder, next_quotient_shift_register}.
  function automatic logic [CNT_W+SUM_W-1:0] div_step(
    input logic [CNT_W-1:0] rem,
    input logic [SUM_W-1:0] quo,
    input logic [CNT_W-1:0] dvs
  );
    logic [CNT_W:0] trial;
    trial = {rem, quo[SUM_W-1]};
    if (trial >= {1'b0, dvs}) begin
      return {trial[CNT_W-1:0] - dvs, quo[SUM_W-2:0], 1'b1};
    end
    return {trial[CNT_W-1:0], quo[SUM_W-2:0], 1'b0};
  endfunction

  // Clamp a quotient to the 10-bit coordinate range.
  function automatic logic [9:0] sat10(input logic [SUM_W-1:0] q);
    return (|q[SUM_W-1:10]) ? 10'h3FF : q[9:0];
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic [SUM_W-1:0]   r_sum_x;
  logic [SUM_W-1:0]   r_sum_y;
  logic [CNT_W-1:0]   r_snap_cnt;
  logic [CNT_W-1:0]   r_rem_x;
  logic [CNT_W-1:0]   r_rem_y;
  logic [SUM_W-1:0]   r_quo_x;
  logic [SUM_W-1:0]   r_quo_y;
  logic [4:0]         r_iter;
  logic [9:0]         r_blue_x;
  logic [9:0]         r_blue_y;
  logic               r_found;
  logic               r_coord_valid;
  logic               r_overrun;

  logic               w_blue;
  logic               w_add;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SUM_W-1:0]   w_sx_nxt;
  logic [SUM_W-1:0]   w_sy_nxt;
  logic [CNT_W-1:0]   w_rem_x_nxt;
  logic [CNT_W-1:0]   w_rem_y_nxt;
  logic [SUM_W-1:0]   w_quo_x_nxt;
  logic [SUM_W-1:0]   w_quo_y_nxt;

  // Classification at COLOR_W+1 bits so channel + MARGIN cannot wrap.
  assign w_blue = pix_valid
               && ({1'b0, pix_b} >= LP_B_MIN)
               && ({1'b0, pix_b} >= ({1'b0, pix_r} + LP_MARGIN))
               && ({1'b0, pix_b} >= ({1'b0, pix_g} + LP_MARGIN));

  // Once the count saturates the sums freeze with it.
  assign w_add     = w_blue && (r_cnt != CNT_MAX);
  assign w_cnt_nxt = r_cnt + CNT_W'(w_add);
  assign w_sx_nxt  = r_sum_x + (w_add ? SUM_W'(pix_x) : '0);
  assign w_sy_nxt  = r_sum_y + (w_add ? SUM_W'(pix_y) : '0);

  assign {w_rem_x_nxt, w_quo_x_nxt} = div_step(r_rem_x, r_quo_x, r_snap_cnt);
  assign {w_rem_y_nxt, w_quo_y_nxt} = div_step(r_rem_y, r_quo_y, r_snap_cnt);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (frame_end) w_state_nxt = S_DIVIDE;
      S_DIVIDE: if (r_iter == LAST_ITER) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_sum_x       <= '0;
      r_sum_y       <= '0;
      r_snap_cnt    <= '0;
      r_rem_x       <= '0;
      r_rem_y       <= '0;
      r_quo_x       <= '0;
      r_quo_y       <= '0;
      r_iter        <= '0;
      r_blue_x      <= '0;
      r_blue_y      <= '0;
      r_found       <= 1'b0;
      r_coord_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      // The pixel sampled with frame_end belongs to the closing frame, so the
      // snapshot takes the *_nxt values while the accumulators clear.
      r_cnt   <= frame_end ? '0 : w_cnt_nxt;
      r_sum_x <= frame_end ? '0 : w_sx_nxt;
      r_sum_y <= frame_end ? '0 : w_sy_nxt;

      r_coord_valid <= (r_state == S_DONE);
      r_overrun     <= frame_end && (r_state != S_IDLE);

      case (r_state)
        S_IDLE: begin
          // The summed dividends are snapshotted straight into the quotient
          // shift registers; dividend bits shift out as quotient bits shift in.
          if (frame_end) begin
            r_snap_cnt <= w_cnt_nxt;
            r_quo_x    <= w_sx_nxt;
            r_quo_y    <= w_sy_nxt;
            r_rem_x    <= '0;
            r_rem_y    <= '0;
            r_iter     <= '0;
          end
        end
        S_DIVIDE: begin
          r_rem_x <= w_rem_x_nxt;
          r_rem_y <= w_rem_y_nxt;
          r_quo_x <= w_quo_x_nxt;
          r_quo_y <= w_quo_y_nxt;
          r_iter  <= r_iter + 5'd1;
        end
        S_DONE: begin
          // A count below threshold (including zero) keeps the old
          // coordinates, so a divide-by-zero quotient never escapes.
          if (r_snap_cnt >= LP_MIN_PIX) begin
            r_blue_x <= sat10(r_quo_x);
            r_blue_y <= sat10(r_quo_y);
            r_found  <= 1'b1;
          end else begin
            r_found  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign blue_x      = r_blue_x;
  assign blue_y      = r_blue_y;
  assign found       = r_found;
  assign coord_valid = r_coord_valid;
  assign overrun     = r_overrun;

endmodule

// File: doc/blue_centroid.md
# blue_centroid

Computes the centroid of blue-classified pixels over each video frame and presents it as a registered coordinate pair (`blue_x`, `blue_y`). It sits directly upstream of the tempo/volume quantiser: it consumes the pixel stream from the camera/VGA capture path and feeds that quantiser's 10-bit coordinate inputs. Per-frame sums are accumulated on the fly. At frame end they are snapshotted and divided by the pixel count with a serial restoring divider, while the next frame accumulates concurrently.

## Interface
- `COLOR_W`, 8, bit width of each colour channel.
- `B_MIN`, 128, minimum blue channel value for a blue pixel.
- `MARGIN`, 32, required lead of blue over red and over green.
- `MIN_PIXELS`, 64, minimum blue-pixel count for a valid detection.
- `clock_in` input 1 system clock; all logic on its rising edge.
- `reset_n` input 1 asynchronous, active-low reset.
- `pix_valid` input 1 qualifies `pix_x`, `pix_y`, `pix_r`, `pix_g` and `pix_b` this cycle.
- `pix_x` input 10 pixel column.
- `pix_y` input 10 pixel row.
- `pix_r`, `pix_g`, `pix_b` input COLOR_W colour channels.
- `frame_end` input 1 one-cycle pulse closing the current frame.
- `blue_x` output 10 centroid column.
- `blue_y` output 10 centroid row.
- `found` output 1 last result met `MIN_PIXELS`.
- `coord_valid` output 1 one-cycle pulse when `blue_x`, `blue_y` and `found` update.
- `overrun` output 1 one-cycle pulse when a `frame_end` is dropped.

## Operation
- **Classification:** a pixel is blue when `pix_valid` is high and all three conditions hold.
  - b ≥ `B_MIN`.
  - b ≥ r + `MARGIN`.
  - b ≥ g + `MARGIN`.
  - Sums are computed at COLOR_W+1 bits, so there is no wrap.
- **Accumulators:**
  - `cnt` is 19 bits; `sum_x` and `sum_y` are 29 bits each.
  - Each blue pixel adds 1 to `cnt` and adds its x and y to the sums.
  - `cnt` saturates at 524287; once saturated, the sums also stop accumulating.
- **Frame close:**
  - A pixel presented in the same cycle as `frame_end` belongs to the closing frame.
  - On that edge the sums and count, including that pixel, are snapshotted and the accumulators are cleared to 0.
- **FSM states:** IDLE, DIVIDE, DONE.
  - IDLE → DIVIDE on `frame_end`; the snapshot is loaded.
  - DIVIDE runs 29 iterations with a 5-bit iteration counter. Two restoring dividers run in parallel (`sum_x`/`cnt` and `sum_y`/`cnt`), one quotient bit each per cycle.
  - DIVIDE → DONE after the 29th iteration.
  - DONE → IDLE unconditionally after one cycle.
- **In DONE:**
  - If the snapshot count ≥ `MIN_PIXELS`: `blue_x` and `blue_y` take the quotients, `found` = 1.
  - Otherwise: `blue_x` and `blue_y` hold their previous values, `found` = 0, and the quotient is ignored. This also covers a zero count, so divide-by-zero never reaches the outputs.
  - Quotients are floor results, saturated to 1023 if they exceed 10 bits.
  - `coord_valid` pulses in both cases.
- **`frame_end` while in DIVIDE or DONE:**
  - Accumulators are still cleared.
  - No snapshot is taken and the running division is unaffected.
  - `overrun` pulses on the following cycle.

## Timing
- **Reset:** while `reset_n` is low, asynchronously:
  - `blue_x` = 0, `blue_y` = 0, `found` = 0, `coord_valid` = 0, `overrun` = 0;
  - accumulators and snapshot = 0;
  - FSM = IDLE.
- **Reset mid-DIVIDE:** aborts the division; no `coord_valid` is produced for that frame.
- **Accumulation:** one-cycle latency from a sampled pixel to the accumulator update; `pix_valid` may be high every cycle.
- **Result latency:** with `frame_end` sampled at edge T, DIVIDE occupies edges T+1..T+29. Outputs update at edge T+30, and `coord_valid` is high for the single cycle after edge T+30.
- **Earliest next frame:** the earliest `frame_end` accepted without `overrun` is at edge T+31.
- **Output stability:** `blue_x`, `blue_y` and `found` are stable between `coord_valid` pulses.

## Test plan
- **Small block:** blue pixels (r=0, g=0, b=255) on an 8×8 block at x 100..107, y 200..207, then `frame_end`.
  - Exactly 30 edges later: `blue_x`=103, `blue_y`=203, `found`=1, single-cycle `coord_valid`.
- **Below threshold:** after the small-block frame, a frame with 63 blue pixels at x=500, y=400.
  - `coord_valid` pulses with `found`=0; `blue_x`=103 and `blue_y`=203 are held.
- **Classification boundaries:**
  - Pixels with b=200, r=169, g=0 (margin fails by 1) and pixels with b=127, r=0, g=0 (below `B_MIN`) are both excluded.
  - Pixels with b=200, r=168, g=168 count.
  - Check against the resulting centroid.
- **Overrun:** a second `frame_end` 10 cycles after the first.
  - `overrun` pulses once; results reflect the first frame only.
  - The next valid frame after that is processed normally.
- **Full frame:** every pixel of 640×480 is blue, with `pix_valid` continuous.
  - `blue_x`=319, `blue_y`=239, `found`=1. Sums are 98150400 and 73574400; count is 307200.
- **Reset mid-operation:** `reset_n` low at T+15 during DIVIDE.
  - All outputs return to 0 immediately and no `coord_valid` appears.
  - The next frame after release yields a correct result.
